// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: arbiter-PUF evaluation sequencer with majority vote (optional PUF_STAB_EN adds resp_stable)
module puf_eval_ctrl #(
   parameter int CHAL_W     = 64,
   parameter int SETTLE_CYC = 8,
   parameter int VOTE_N     = 15,
   parameter int CNT_W      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CHAL_W-1:0] challenge,
   output logic              busy,
   output logic [CHAL_W-1:0] puf_chal,
   output logic              puf_launch,
   input  logic              arb_q,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_bit,
`ifdef PUF_STAB_EN
   output logic              resp_stable,
`endif
   output logic [CNT_W-1:0]  ones_count
);
   typedef enum logic [2:0] {IDLE, LOAD, FIRE, SAMPLE, REARM, DONE} state_t;
   localparam logic [7:0]       PH_LAST = 8'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] VN      = CNT_W'(VOTE_N);
   localparam logic [CNT_W-1:0] HALF    = CNT_W'(VOTE_N / 2);
   state_t           state, state_nx;
   logic [7:0]       phase;
   logic [CNT_W-1:0] votes;
   logic             arb_m, arb_s;
   logic             phase_end;
   assign phase_end = (phase == PH_LAST);
   // two-flop synchronizer for the asynchronous arbiter output
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {arb_s, arb_m} <= 2'b00;
      else {arb_s, arb_m} <= {arb_m, arb_q};
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // next-state logic; each timed phase ends on the last phase-counter count
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? LOAD : IDLE;
         LOAD:    state_nx = phase_end ? FIRE : LOAD;
         FIRE:    state_nx = phase_end ? SAMPLE : FIRE;
         SAMPLE:  state_nx = REARM;
         REARM:   state_nx = phase_end ? ((votes == VN) ? DONE : FIRE) : REARM;
         DONE:    state_nx = resp_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   // registered outputs derived from the next state so launch/valid/busy are glitch-free
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         phase      <= '0;
         busy       <= 1'b0;
         puf_launch <= 1'b0;
         resp_valid <= 1'b0;
      end else begin
         phase      <= (state_nx == state) ? phase + 8'd1 : 8'd0;
         busy       <= (state_nx != IDLE);
         puf_launch <= (state_nx inside {FIRE, SAMPLE});
         resp_valid <= (state_nx == DONE);
      end
   // challenge capture, vote accumulation and result registers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         puf_chal    <= '0;
         votes       <= '0;
         ones_count  <= '0;
         resp_bit    <= 1'b0;
`ifdef PUF_STAB_EN
         resp_stable <= 1'b0;
`endif
      end else if (state == IDLE && start) begin
         puf_chal    <= challenge;
         votes       <= '0;
         ones_count  <= '0;
         resp_bit    <= 1'b0;
`ifdef PUF_STAB_EN
         resp_stable <= 1'b0;
`endif
      end else if (state == SAMPLE) begin
         votes      <= votes + CNT_W'(1);
         ones_count <= ones_count + CNT_W'(arb_s);
      end else if (state == REARM && state_nx == DONE) begin
         resp_bit    <= (ones_count > HALF);
`ifdef PUF_STAB_EN
         resp_stable <= (ones_count == '0) || (ones_count == VN);
`endif
      end
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: scoreboard bench for puf_eval_ctrl with SETTLE_CYC=3, VOTE_N=3
module tb_puf_eval_ctrl;
   localparam int CHAL_W = 64;
   localparam int CW     = 2;
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              arb_q = 1'b0;
   logic              resp_ready = 1'b0;
   logic [CHAL_W-1:0] challenge = '0;
   logic [CHAL_W-1:0] puf_chal;
   logic              busy, puf_launch, resp_valid, resp_bit;
   logic [CW-1:0]     ones_count;
`ifdef PUF_STAB_EN
   logic              resp_stable;
`endif
   int passed = 0;
   int total  = 0;
   int rises  = 0;
   int run    = 0;
   bit chk_len = 1'b1;
   logic prev_l = 1'b0;
   logic prev_v = 1'b0;
   typedef struct packed {logic b; logic [CW-1:0] n; logic st;} exp_t;
   exp_t sbq[$];
   exp_t got;
   bit   arb_vals[$];

   always #5 clk = ~clk;

   puf_eval_ctrl #(.CHAL_W(CHAL_W), .SETTLE_CYC(3), .VOTE_N(3), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge), .busy(busy),
      .puf_chal(puf_chal), .puf_launch(puf_launch), .arb_q(arb_q),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bit(resp_bit),
`ifdef PUF_STAB_EN
      .resp_stable(resp_stable),
`endif
      .ones_count(ones_count));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // arbiter model: each race resolves to the next queued value when the launch edge rises
   initial forever begin
      @(posedge puf_launch);
      arb_q = (arb_vals.size() != 0) ? arb_vals.pop_front() : 1'b0;
   end

   // launch monitor: counts rising edges and checks each high pulse lasts FIRE+SAMPLE = 4 cycles
   initial forever begin
      @(negedge clk);
      if (puf_launch && !prev_l) rises++;
      if (puf_launch) run++;
      else begin
         if (prev_l && chk_len) check("launch_high_cycles", 64'(run), 64'd4);
         run = 0;
      end
      prev_l = puf_launch;
   end

   // response monitor: pops the scoreboard whenever a new response is presented
   initial forever begin
      @(negedge clk);
      if (resp_valid && !prev_v) begin
         if (sbq.size() == 0) check("unexpected_response", 64'd1, 64'd0);
         else begin
            got = sbq.pop_front();
            check("resp_bit", 64'(resp_bit), 64'(got.b));
            check("ones_count", 64'(ones_count), 64'(got.n));
`ifdef PUF_STAB_EN
            check("resp_stable", 64'(resp_stable), 64'(got.st));
`endif
         end
      end
      prev_v = resp_valid;
   end

   task automatic run_eval(input logic [63:0] chal, input bit v0, input bit v1, input bit v2,
                           input bit pulse, input int hold, input bit hs_start);
      int e = 0;
      int r0;
      int n;
      bit ok = 1'b1;
      logic b0;
      logic [CW-1:0] n0;
      n = int'(v0) + int'(v1) + int'(v2);
      arb_vals.push_back(v0);
      arb_vals.push_back(v1);
      arb_vals.push_back(v2);
      sbq.push_back('{b: (n > 1), n: CW'(n), st: (n == 0 || n == 3)});
      @(negedge clk);
      start = 1'b1;
      challenge = chal;
      r0 = rises;
      @(posedge clk);
      #1 start = 1'b0;
      check("puf_chal_capture", puf_chal, chal);
      check("busy_after_accept", 64'(busy), 64'd1);
      while (!resp_valid && e < 100) begin
         @(posedge clk);
         #1 e++;
         start = pulse && (e == 5 || e == 12);
         challenge = start ? ~chal : chal;
      end
      start = 1'b0;
      check("latency", 64'(e), 64'd24);
      check("launch_rises", 64'(rises - r0), 64'd3);
      check("puf_chal_hold", puf_chal, chal);
      b0 = resp_bit;
      n0 = ones_count;
      repeat (hold) begin
         @(negedge clk);
         ok &= resp_valid && busy && resp_bit == b0 && ones_count == n0;
      end
      if (hold > 0) check("hold_stable", 64'(ok), 64'd1);
      @(negedge clk);
      resp_ready = 1'b1;
      if (hs_start) begin
         start = 1'b1;
         challenge = ~chal;
      end
      @(posedge clk);
      #1 resp_ready = 1'b0;
      start = 1'b0;
      check("idle_after_handshake", 64'(busy), 64'd0);
      check("valid_drop", 64'(resp_valid), 64'd0);
      @(negedge clk);
      check("still_idle", 64'(busy), 64'd0);
      check("chal_after_done", puf_chal, chal);
      check("ones_hold", 64'(ones_count), 64'(n));
   endtask

   initial begin
      #3;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_launch", 64'(puf_launch), 64'd0);
      check("rst_valid", 64'(resp_valid), 64'd0);
      check("rst_chal", puf_chal, 64'd0);
      check("rst_ones", 64'(ones_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_eval(64'hA5A5_0000_FFFF_1234, 1, 1, 1, 0, 0, 0);
      run_eval(64'h0123_4567_89AB_CDEF, 1, 0, 1, 0, 0, 0);
      run_eval(64'hDEAD_BEEF_0000_0001, 0, 0, 1, 0, 10, 0);
      run_eval(64'h1111_2222_3333_4444, 0, 0, 0, 1, 0, 0);
      arb_vals.push_back(1'b1);
      arb_vals.push_back(1'b1);
      arb_vals.push_back(1'b1);
      @(negedge clk);
      start = 1'b1;
      challenge = 64'hFACE_0000_0000_CAFE;
      @(posedge clk);
      #1 start = 1'b0;
      chk_len = 1'b0;
      repeat (11) @(posedge clk);
      #2 check("launch_in_fire2", 64'(puf_launch), 64'd1);
      rst_n = 1'b0;
      #1 check("rst_mid_launch", 64'(puf_launch), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_valid", 64'(resp_valid), 64'd0);
      check("rst_mid_ones", 64'(ones_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      arb_vals.delete();
      repeat (2) @(negedge clk);
      chk_len = 1'b1;
      run_eval(64'h0F0F_0F0F_F0F0_F0F0, 1, 1, 0, 0, 0, 0);
      run_eval(64'h8000_0000_0000_0001, 0, 1, 1, 0, 0, 1);
      repeat (5) @(negedge clk);
      check("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
